memwb_stage: RTL and testbench

- Final pipeline stage of the CPU, after execute. Consumes the memory and bus control bits that decode produces, performs data-memory loads and stores and data-bus transactions, and returns the register writeback triple plus a pipeline stall to the fetch/decode stage.
- Data memory is a synchronous RAM with 1-cycle read latency. The data bus is a req/ack handshake to an external agent, such as the NN accelerator.

---
 rtl/memwb_stage_if.sv | 29 ++
 rtl/memwb_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_memwb_stage.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memwb_stage_if.sv
// -----------------------------------------------------------------------------
// memwb_stage_if
// Data-bus handshake between the memwb stage (master) and an external agent
// such as the NN accelerator (slave).
//   oBusReq   : request, held until the cycle after iBusAck
//   oBusWe    : 1 = write, 0 = read
//   oBusAddr  : transaction address
//   oBusWdata : write data
//   iBusAck   : transaction complete
//   iBusRdata : read data, valid with iBusAck
// -----------------------------------------------------------------------------
interface memwb_stage_if;
    logic        oBusReq;
    logic        oBusWe;
    logic [15:0] oBusAddr;
    logic [15:0] oBusWdata;
    logic        iBusAck;
    logic [15:0] iBusRdata;

    modport master (
        output oBusReq, oBusWe, oBusAddr, oBusWdata,
        input  iBusAck, iBusRdata
    );

    modport slave (
        input  oBusReq, oBusWe, oBusAddr, oBusWdata,
        output iBusAck, iBusRdata
    );
endinterface

// File: rtl/memwb_stage.sv
// -----------------------------------------------------------------------------
// memwb_stage
// Final CPU pipeline stage: data-memory loads/stores, data-bus transactions,
// and the registered writeback triple plus a combinational stall upstream.
//
// Optional feature: define MEMWB_BUS_TIMEOUT_EN to abort bus transactions
// that see no ack within TIMEOUT_CYCLES BUS cycles (sticky oBusErr, reads
// write back 16'hDEAD). Undefined: BUS waits forever and oBusErr is 0.
//
// Ports:
//   iclk, irst_n         clock, async active-low reset
//   iALUResult           address / ALU writeback value
//   iStoreData           store / bus write data
//   iWriteReg, iWriteRegAddr, iMemRead, iMemWrite, iMemtoReg,
//   iBustoReg, iBusWrite decode control bits
//   oDmemAddr/Wdata/Re/We, iDmemRdata   synchronous RAM, 1-cycle read latency
//   bus                  data-bus handshake (memwb_stage_if.master)
//   oWriteReg, oMemtoReg, oBustoReg, oWriteRegAddr, oWriteRegData  writeback
//   stall                upstream holds its inputs while high
//   oBusErr              sticky bus timeout flag
// -----------------------------------------------------------------------------
module memwb_stage #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic [15:0]       iALUResult,
    input  logic [15:0]       iStoreData,
    input  logic              iWriteReg,
    input  logic [3:0]        iWriteRegAddr,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic              iMemtoReg,
    input  logic              iBustoReg,
    input  logic              iBusWrite,
    output logic [ADDR_W-1:0] oDmemAddr,
    output logic [15:0]       oDmemWdata,
    output logic              oDmemRe,
    output logic              oDmemWe,
    input  logic [15:0]       iDmemRdata,
    memwb_stage_if.master     bus,
    output logic              oWriteReg,
    output logic              oMemtoReg,
    output logic              oBustoReg,
    output logic [3:0]        oWriteRegAddr,
    output logic [15:0]       oWriteRegData,
    output logic              stall,
    output logic              oBusErr
);

    typedef enum logic [1:0] {StIdle, StMemRd, StBus} state_e;

    state_e r_state;
    state_e w_state_next;

    logic        w_bus_op;
    logic        w_load;
    logic        w_enter_bus;
    logic        w_in_bus;
    logic        w_timeout;
    logic        w_done;
    logic        w_unused;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [15:0] r_bus_addr;
    logic [15:0] r_bus_wdata;

    logic        r_wb_we;
    logic        r_wb_mem;
    logic        r_wb_bus;
    logic [3:0]  r_wb_addr;
    logic [15:0] r_wb_data;
    logic        w_wb_we;
    logic        w_wb_mem;
    logic        w_wb_bus;
    logic [3:0]  w_wb_addr;
    logic [15:0] w_wb_data;

    // Bus bits win over iMemRead if decode ever sets both.
    assign w_bus_op    = iBustoReg | iBusWrite;
    assign w_load      = iMemRead & ~w_bus_op;
    assign w_enter_bus = (r_state == StIdle) & w_bus_op;
    assign w_in_bus    = (r_state == StBus);
    assign w_done      = w_in_bus & (bus.iBusAck | w_timeout);

    assign oDmemAddr  = iALUResult[ADDR_W-1:0];
    assign oDmemWdata = iStoreData;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_bus_op) begin
                    w_state_next = StBus;
                end else if (w_load) begin
                    w_state_next = StMemRd;
                end
            end
            StMemRd: w_state_next = StIdle;
            StBus: begin
                if (w_done) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        stall   = 1'b0;
        oDmemRe = 1'b0;
        oDmemWe = 1'b0;
        unique case (r_state)
            StIdle: begin
                stall   = iMemRead | w_bus_op;
                oDmemRe = w_load;
                oDmemWe = iMemWrite & ~iMemRead & ~w_bus_op;
            end
            StBus:   stall = ~(bus.iBusAck | w_timeout);
            default: stall = 1'b0;
        endcase
    end

    // ---------------------------------------------------------- writeback
    // Flags default to a bubble; addr/data hold their last value on bubbles.
    always_comb begin
        w_wb_we   = 1'b0;
        w_wb_mem  = 1'b0;
        w_wb_bus  = 1'b0;
        w_wb_addr = r_wb_addr;
        w_wb_data = r_wb_data;
        unique case (r_state)
            StIdle: begin
                if (!stall) begin
                    w_wb_we   = iWriteReg & ~iMemWrite & ~iBusWrite;
                    w_wb_addr = iWriteRegAddr;
                    w_wb_data = iALUResult;
                end
            end
            StMemRd: begin
                w_wb_we   = 1'b1;
                w_wb_mem  = 1'b1;
                w_wb_addr = iWriteRegAddr;
                w_wb_data = iDmemRdata;
            end
            StBus: begin
                if (w_done && !r_bus_we) begin
                    w_wb_we   = 1'b1;
                    w_wb_bus  = 1'b1;
                    w_wb_addr = iWriteRegAddr;
                    w_wb_data = bus.iBusAck ? bus.iBusRdata : 16'hDEAD;
                end
            end
            default: w_wb_we = 1'b0;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_wb_we   <= 1'b0;
            r_wb_mem  <= 1'b0;
            r_wb_bus  <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_we   <= w_wb_we;
            r_wb_mem  <= w_wb_mem;
            r_wb_bus  <= w_wb_bus;
            r_wb_addr <= w_wb_addr;
            r_wb_data <= w_wb_data;
        end
    end

    assign oWriteReg     = r_wb_we;
    assign oMemtoReg     = r_wb_mem;
    assign oBustoReg     = r_wb_bus;
    assign oWriteRegAddr = r_wb_addr;
    assign oWriteRegData = r_wb_data;

    // ---------------------------------------------------------------- bus
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else if (w_enter_bus) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= iBusWrite;
            r_bus_addr  <= iALUResult;
            r_bus_wdata <= iStoreData;
        end else if (w_done) begin
            r_bus_req <= 1'b0;
        end
    end

    assign bus.oBusReq   = r_bus_req;
    assign bus.oBusWe    = r_bus_we;
    assign bus.oBusAddr  = r_bus_addr;
    assign bus.oBusWdata = r_bus_wdata;

`ifdef MEMWB_BUS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] r_tmo_cnt;
    logic            r_bus_err;

    // Counter equals the number of unacked BUS cycles already elapsed, so
    // the abort lands on the TIMEOUT_CYCLES-th BUS cycle.
    assign w_timeout = w_in_bus & ~bus.iBusAck &
                       (r_tmo_cnt == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_tmo_cnt <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_enter_bus) begin
                r_tmo_cnt <= '0;
            end else if (w_in_bus && !bus.iBusAck) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign oBusErr  = r_bus_err;
    assign w_unused = iMemtoReg;
`else
    assign w_timeout = 1'b0;
    assign oBusErr   = 1'b0;
    assign w_unused  = iMemtoReg ^ (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// -----------------------------------------------------------------------------
// tb_memwb_stage
// Directed and randomized checks of memwb_stage against a behavioural model:
// an array for data memory contents and per-instruction-class expectations
// for stall length, strobes, bus fields and writeback.
// -----------------------------------------------------------------------------
module tb_memwb_stage;

    localparam int K_ALU = 0;
    localparam int K_ST  = 1;
    localparam int K_LD  = 2;
    localparam int K_BRD = 3;
    localparam int K_BWR = 4;

    logic        iclk = 1'b0;
    logic        irst_n;
    logic [15:0] iALUResult;
    logic [15:0] iStoreData;
    logic        iWriteReg;
    logic [3:0]  iWriteRegAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic        iMemtoReg;
    logic        iBustoReg;
    logic        iBusWrite;
    logic [7:0]  oDmemAddr;
    logic [15:0] oDmemWdata;
    logic        oDmemRe;
    logic        oDmemWe;
    logic [15:0] iDmemRdata;
    logic        oWriteReg;
    logic        oMemtoReg;
    logic        oBustoReg;
    logic [3:0]  oWriteRegAddr;
    logic [15:0] oWriteRegData;
    logic        stall;
    logic        oBusErr;

    memwb_stage_if bus_if();

    memwb_stage #(
        .ADDR_W         (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .iclk          (iclk),
        .irst_n        (irst_n),
        .iALUResult    (iALUResult),
        .iStoreData    (iStoreData),
        .iWriteReg     (iWriteReg),
        .iWriteRegAddr (iWriteRegAddr),
        .iMemRead      (iMemRead),
        .iMemWrite     (iMemWrite),
        .iMemtoReg     (iMemtoReg),
        .iBustoReg     (iBustoReg),
        .iBusWrite     (iBusWrite),
        .oDmemAddr     (oDmemAddr),
        .oDmemWdata    (oDmemWdata),
        .oDmemRe       (oDmemRe),
        .oDmemWe       (oDmemWe),
        .iDmemRdata    (iDmemRdata),
        .bus           (bus_if),
        .oWriteReg     (oWriteReg),
        .oMemtoReg     (oMemtoReg),
        .oBustoReg     (oBustoReg),
        .oWriteRegAddr (oWriteRegAddr),
        .oWriteRegData (oWriteRegData),
        .stall         (stall),
        .oBusErr       (oBusErr)
    );

    always #5 iclk = ~iclk;

    // Synchronous RAM driven only by the DUT strobes.
    logic [15:0] ram [256];
    always @(posedge iclk) begin
        if (oDmemWe) ram[oDmemAddr] <= oDmemWdata;
        if (oDmemRe) iDmemRdata <= ram[oDmemAddr];
    end

    // Reference memory contents, updated when the model retires a store.
    logic [15:0] exp_mem [256];
    bit   [255:0] written;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iclk);
        #1;
    endtask

    task automatic clear_inputs();
        iALUResult    = '0;
        iStoreData    = '0;
        iWriteReg     = 1'b0;
        iWriteRegAddr = '0;
        iMemRead      = 1'b0;
        iMemWrite     = 1'b0;
        iMemtoReg     = 1'b0;
        iBustoReg     = 1'b0;
        iBusWrite     = 1'b0;
        bus_if.iBusAck   = 1'b0;
        bus_if.iBusRdata = '0;
    endtask

    // Runs one instruction from an IDLE cycle boundary (posedge+1) to its
    // retirement, checking every cycle. ack_at = BUS cycle carrying iBusAck.
    task automatic run_op(input int kind, input logic [15:0] alu, input logic [15:0] sd,
                          input logic [3:0] rd, input logic wr, input int ack_at,
                          input logic [15:0] brd);
        logic is_bus;
        is_bus        = (kind == K_BRD) || (kind == K_BWR);
        iALUResult    = alu;
        iStoreData    = sd;
        iWriteRegAddr = rd;
        iWriteReg     = wr;
        iMemWrite     = (kind == K_ST);
        iMemRead      = (kind == K_LD);
        iMemtoReg     = (kind == K_LD);
        iBustoReg     = (kind == K_BRD);
        iBusWrite     = (kind == K_BWR);
        bus_if.iBusAck   = 1'b0;
        bus_if.iBusRdata = 16'($urandom);
        #1;
        if (kind == K_ALU || kind == K_ST) begin
            chk1("stall_alu_st", stall, 1'b0);
            chk1("dmem_we", oDmemWe, kind == K_ST);
            if (kind == K_ST) begin
                chk16("dmem_addr_st", 16'(oDmemAddr), 16'(alu[7:0]));
                chk16("dmem_wdata", oDmemWdata, sd);
                exp_mem[alu[7:0]] = sd;
                written[alu[7:0]] = 1'b1;
            end
            cyc();
            chk1("wb_we", oWriteReg, wr && (kind == K_ALU));
            chk16("wb_flags_alu", 16'({oMemtoReg, oBustoReg}), 16'h0);
            if (wr && kind == K_ALU) begin
                chk16("wb_addr_alu", 16'(oWriteRegAddr), 16'(rd));
                chk16("wb_data_alu", oWriteRegData, alu);
            end
        end else if (kind == K_LD) begin
            chk1("stall_ld0", stall, 1'b1);
            chk1("dmem_re0", oDmemRe, 1'b1);
            chk16("dmem_addr_ld", 16'(oDmemAddr), 16'(alu[7:0]));
            cyc();
            chk16("bubble_ld", 16'({oWriteReg, oMemtoReg, oBustoReg}), 16'h0);
            #1;
            chk1("stall_ld1", stall, 1'b0);
            chk1("dmem_re1", oDmemRe, 1'b0);
            cyc();
            chk16("wb_flags_ld", 16'({oWriteReg, oMemtoReg, oBustoReg}), 16'(3'b110));
            chk16("wb_addr_ld", 16'(oWriteRegAddr), 16'(rd));
            chk16("wb_data_ld", oWriteRegData, exp_mem[alu[7:0]]);
        end else if (is_bus) begin
            chk1("stall_bus0", stall, 1'b1);
            chk1("req_before", bus_if.oBusReq, 1'b0);
            cyc();
            chk1("req_set", bus_if.oBusReq, 1'b1);
            chk16("bus_addr", bus_if.oBusAddr, alu);
            chk1("bus_we", bus_if.oBusWe, kind == K_BWR);
            if (kind == K_BWR) chk16("bus_wdata", bus_if.oBusWdata, sd);
            chk16("bubble_bus0", 16'({oWriteReg, oMemtoReg, oBustoReg}), 16'h0);
            for (int k = 1; k <= ack_at; k++) begin
                bus_if.iBusAck = (k == ack_at);
                if (k == ack_at) bus_if.iBusRdata = brd;
                #1;
                chk1("stall_bus", stall, k != ack_at);
                cyc();
                if (k < ack_at) begin
                    chk1("req_hold", bus_if.oBusReq, 1'b1);
                    chk16("bubble_bus", 16'({oWriteReg, oMemtoReg, oBustoReg}), 16'h0);
                end else begin
                    chk1("req_drop", bus_if.oBusReq, 1'b0);
                    if (kind == K_BRD) begin
                        chk16("wb_flags_brd", 16'({oWriteReg, oMemtoReg, oBustoReg}),
                              16'(3'b101));
                        chk16("wb_addr_brd", 16'(oWriteRegAddr), 16'(rd));
                        chk16("wb_data_brd", oWriteRegData, brd);
                    end else begin
                        chk16("wb_flags_bwr", 16'({oWriteReg, oMemtoReg, oBustoReg}), 16'h0);
                    end
                end
            end
            bus_if.iBusAck = 1'b0;
        end
    endtask

    initial begin
        int          kind;
        logic [15:0] alu;
        logic [15:0] sd;

        written = '0;
        clear_inputs();
        irst_n = 1'b0;
        #3;
        chk16("rst_wb", 16'({oWriteReg, oMemtoReg, oBustoReg}), 16'h0);
        chk16("rst_wb_data", oWriteRegData, 16'h0);
        chk1("rst_req", bus_if.oBusReq, 1'b0);
        chk1("rst_err", oBusErr, 1'b0);
        @(negedge iclk);
        irst_n = 1'b1;
        cyc();

        // ALU op
        run_op(K_ALU, 16'h1234, 16'h0, 4'd5, 1'b1, 0, 16'h0);

        // Reset in the middle of a bus read
        iALUResult = 16'h2222;
        iBustoReg  = 1'b1;
        iWriteRegAddr = 4'd9;
        cyc();
        chk1("req_pre_rst", bus_if.oBusReq, 1'b1);
        #2;
        irst_n = 1'b0;
        #1;
        chk1("req_async_rst", bus_if.oBusReq, 1'b0);
        chk16("wb_async_rst", 16'({oWriteReg, oMemtoReg, oBustoReg}), 16'h0);
        chk16("wb_addr_async_rst", 16'(oWriteRegAddr), 16'h0);
        chk16("wb_data_async_rst", oWriteRegData, 16'h0);
        chk16("bus_addr_async_rst", bus_if.oBusAddr, 16'h0);
        clear_inputs();
        @(negedge iclk);
        irst_n = 1'b1;
        cyc();
        run_op(K_ALU, 16'h0F0F, 16'h0, 4'd3, 1'b1, 0, 16'h0);

        // Store then load at 8'h10
        run_op(K_ST, 16'h0010, 16'hBEEF, 4'd2, 1'b1, 0, 16'h0);
        run_op(K_LD, 16'h0010, 16'h0, 4'd7, 1'b1, 0, 16'h0);

        // Bus read acked on the 3rd BUS cycle, bus write acked on the 1st
        run_op(K_BRD, 16'hA000, 16'h0, 4'd4, 1'b1, 3, 16'h00A5);
        run_op(K_BWR, 16'hA002, 16'h5A5A, 4'd6, 1'b0, 1, 16'h0);

`ifdef MEMWB_BUS_TIMEOUT_EN
        // Unacked read aborts on the 4th BUS cycle
        clear_inputs();
        iALUResult    = 16'h4000;
        iBustoReg     = 1'b1;
        iWriteRegAddr = 4'd8;
        #1;
        chk1("stall_tmo0", stall, 1'b1);
        cyc();
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk1("stall_tmo", stall, k != 4);
            cyc();
            if (k < 4) begin
                chk1("req_tmo_hold", bus_if.oBusReq, 1'b1);
                chk1("err_tmo_low", oBusErr, 1'b0);
            end else begin
                chk1("req_tmo_drop", bus_if.oBusReq, 1'b0);
                chk1("err_tmo_set", oBusErr, 1'b1);
                chk16("wb_flags_tmo", 16'({oWriteReg, oMemtoReg, oBustoReg}), 16'(3'b101));
                chk16("wb_data_tmo", oWriteRegData, 16'hDEAD);
            end
        end
`else
        // Without timeout the bus waits as long as it takes
        clear_inputs();
        iALUResult    = 16'h4000;
        iBustoReg     = 1'b1;
        iWriteRegAddr = 4'd8;
        cyc();
        for (int k = 1; k <= 10; k++) begin
            #1;
            chk1("stall_wait", stall, 1'b1);
            cyc();
            chk1("req_wait", bus_if.oBusReq, 1'b1);
            chk1("err_zero", oBusErr, 1'b0);
        end
        bus_if.iBusAck   = 1'b1;
        bus_if.iBusRdata = 16'h1357;
        #1;
        chk1("stall_late_ack", stall, 1'b0);
        cyc();
        chk1("req_late_ack", bus_if.oBusReq, 1'b0);
        chk16("wb_data_late_ack", oWriteRegData, 16'h1357);
`endif
        clear_inputs();

        // Random instruction stream
        for (int n = 0; n < 120; n++) begin
            kind = int'($urandom_range(4, 0));
            alu  = 16'($urandom);
            alu[7:0] = {4'h3, alu[3:0]};
            sd   = 16'($urandom);
            if (kind == K_LD && !written[alu[7:0]]) kind = K_ST;
            run_op(kind, alu, sd, 4'($urandom), 1'($urandom), int'($urandom_range(3, 1)),
                   16'($urandom));
        end

`ifdef MEMWB_BUS_TIMEOUT_EN
        chk1("err_sticky", oBusErr, 1'b1);
`else
        chk1("err_tied", oBusErr, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
